// File: rtl/idu_is_bju_mask_q.sv
// In-order queue of unresolved branches issued to the BJU pipe; exposes the oldest one.
// Optional combinational create-to-head bypass when empty: define IDU_BJU_MASK_BYPASS_EN.
module idu_is_bju_mask_q #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned IID_W    = 7,
  parameter int unsigned PIPE_W   = 5,
  parameter int unsigned BJU_PIPE = 2
) (
  input  logic                         clk,
  input  logic                         rst_clk,
  input  logic                         rtu_global_flush,
  input  logic                         y_idu_is_stall_ctrl,
  input  logic                         idu_idu_is_vld,
  input  logic [IID_W-1:0]             rtu_idu_is_iid,
  input  logic [PIPE_W-1:0]            idu_idu_is_pipe,
  input  logic                         bju_resolve_vld,
  input  logic [IID_W-1:0]             bju_resolve_iid,
  input  logic                         bju_resolve_nojump,
  output logic                         biq_mask_stall_ctrl,
  output logic [$clog2(DEPTH+1)-1:0]   biq_mask_num,
  output logic                         x_lsiq_vld,
  output logic [IID_W-1:0]             x_lsiq_iid,
  output logic                         biq_mask_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NUM_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IID_W-1:0] iid_q [DEPTH];
  logic [IID_W-1:0] iid_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             err_q, err_d;

  logic create, hit, pop, mispred, miss;

  assign biq_mask_stall_ctrl = (num_q == NUM_W'(DEPTH));
  assign create  = idu_idu_is_vld & idu_idu_is_pipe[BJU_PIPE] & ~y_idu_is_stall_ctrl
                 & ~biq_mask_stall_ctrl;
  assign hit     = bju_resolve_vld & vld_q[head_q] & (bju_resolve_iid == iid_q[head_q]);
  assign pop     = hit & bju_resolve_nojump;
  assign mispred = hit & ~bju_resolve_nojump;
  assign miss    = bju_resolve_vld & ~hit;

  always_comb begin
    vld_d  = vld_q;
    iid_d  = iid_q;
    head_d = head_q;
    tail_d = tail_q;
    num_d  = num_q;
    err_d  = err_q;
    if (rtu_global_flush || mispred) begin
      // A redirect discards the head and everything younger, including a same-cycle create.
      vld_d  = '0;
      for (int i = 0; i < DEPTH; i++) iid_d[i] = '0;
      head_d = '0;
      tail_d = '0;
      num_d  = '0;
      if (rtu_global_flush) err_d = 1'b0;
    end else begin
      if (pop) begin
        vld_d[head_q] = 1'b0;
        iid_d[head_q] = '0;
        head_d        = head_q + PTR_W'(1);
      end
      if (create) begin
        vld_d[tail_q] = 1'b1;
        iid_d[tail_q] = rtu_idu_is_iid;
        tail_d        = tail_q + PTR_W'(1);
      end
      unique case ({create, pop})
        2'b10:   num_d = num_q + NUM_W'(1);
        2'b01:   num_d = num_q - NUM_W'(1);
        default: num_d = num_q;
      endcase
      if (miss) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) iid_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      num_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      for (int i = 0; i < DEPTH; i++) iid_q[i] <= iid_d[i];
      head_q <= head_d;
      tail_q <= tail_d;
      num_q  <= num_d;
      err_q  <= err_d;
    end
  end

  assign biq_mask_num = num_q;
  assign biq_mask_err = err_q;

`ifdef IDU_BJU_MASK_BYPASS_EN
  // Popped/flushed entries have their IID cleared, so an invalid head always reads 0.
  always_comb begin
    x_lsiq_vld = vld_q[head_q];
    x_lsiq_iid = iid_q[head_q];
    if (num_q == '0 && create) begin
      x_lsiq_vld = 1'b1;
      x_lsiq_iid = rtu_idu_is_iid;
    end
  end
`else
  assign x_lsiq_vld = vld_q[head_q];
  assign x_lsiq_iid = iid_q[head_q];
`endif

endmodule

// File: tb/tb_idu_is_bju_mask_q.sv
// Directed self-checking bench for idu_is_bju_mask_q (DEPTH=8 default build).
module tb_idu_is_bju_mask_q;

  logic       clk = 1'b0;
  logic       rst_clk;
  logic       rtu_global_flush, y_idu_is_stall_ctrl, idu_idu_is_vld;
  logic [6:0] rtu_idu_is_iid;
  logic [4:0] idu_idu_is_pipe;
  logic       bju_resolve_vld, bju_resolve_nojump;
  logic [6:0] bju_resolve_iid;
  logic       biq_mask_stall_ctrl, x_lsiq_vld, biq_mask_err;
  logic [3:0] biq_mask_num;
  logic [6:0] x_lsiq_iid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idu_is_bju_mask_q dut (
    .clk                 (clk),
    .rst_clk             (rst_clk),
    .rtu_global_flush    (rtu_global_flush),
    .y_idu_is_stall_ctrl (y_idu_is_stall_ctrl),
    .idu_idu_is_vld      (idu_idu_is_vld),
    .rtu_idu_is_iid      (rtu_idu_is_iid),
    .idu_idu_is_pipe     (idu_idu_is_pipe),
    .bju_resolve_vld     (bju_resolve_vld),
    .bju_resolve_iid     (bju_resolve_iid),
    .bju_resolve_nojump  (bju_resolve_nojump),
    .biq_mask_stall_ctrl (biq_mask_stall_ctrl),
    .biq_mask_num        (biq_mask_num),
    .x_lsiq_vld          (x_lsiq_vld),
    .x_lsiq_iid          (x_lsiq_iid),
    .biq_mask_err        (biq_mask_err)
  );

  task automatic idle_inputs();
    rtu_global_flush    = 1'b0;
    y_idu_is_stall_ctrl = 1'b0;
    idu_idu_is_vld      = 1'b0;
    rtu_idu_is_iid      = '0;
    idu_idu_is_pipe     = '0;
    bju_resolve_vld     = 1'b0;
    bju_resolve_iid     = '0;
    bju_resolve_nojump  = 1'b0;
  endtask

  // Drive one cycle of stimulus, step past the edge, return inputs to idle.
  task automatic do_cycle(input bit cr, input logic [6:0] ciid, input bit rv,
                          input logic [6:0] riid, input bit nj, input bit fl);
    idu_idu_is_vld     = cr;
    idu_idu_is_pipe    = cr ? 5'b00100 : 5'b00000;
    rtu_idu_is_iid     = ciid;
    bju_resolve_vld    = rv;
    bju_resolve_iid    = riid;
    bju_resolve_nojump = nj;
    rtu_global_flush   = fl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_clk = 1'b1;
    #3;
    total++;
    if ({biq_mask_stall_ctrl, biq_mask_num, x_lsiq_vld, x_lsiq_iid, biq_mask_err} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs got stall=%b num=%0d vld=%b iid=%0d err=%b want all 0",
               biq_mask_stall_ctrl, biq_mask_num, x_lsiq_vld, x_lsiq_iid, biq_mask_err);
    end
    @(posedge clk); #1;
    rst_clk = 1'b0;
    @(posedge clk); #1;
    total++;
    if (biq_mask_num !== 4'd0 || x_lsiq_vld !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got num=%0d vld=%b want 0 0", biq_mask_num, x_lsiq_vld);
    end
  endtask

  task automatic test_create_qual();
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    idu_idu_is_vld = 1'b1; idu_idu_is_pipe = 5'b01011; rtu_idu_is_iid = 7'd20;
    @(posedge clk); #1;
    idle_inputs();
    idu_idu_is_vld = 1'b1; idu_idu_is_pipe = 5'b00100; rtu_idu_is_iid = 7'd21;
    y_idu_is_stall_ctrl = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if (biq_mask_num !== 4'd0 || x_lsiq_vld !== 1'b0) begin
      bad++;
      $display("FAIL create_qualify got num=%0d vld=%b want 0 0", biq_mask_num, x_lsiq_vld);
    end
  endtask

  task automatic test_fill();
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      do_cycle(1'b1, 7'(i), 1'b0, 7'd0, 1'b0, 1'b0);
      if (i == 7) begin
        total++;
        if (biq_mask_stall_ctrl !== 1'b0 || biq_mask_num !== 4'd7) begin
          bad++;
          $display("FAIL fill_7 got stall=%b num=%0d want 0 7", biq_mask_stall_ctrl, biq_mask_num);
        end
      end
    end
    total++;
    if (biq_mask_stall_ctrl !== 1'b1 || biq_mask_num !== 4'd8 || x_lsiq_iid !== 7'd1
        || x_lsiq_vld !== 1'b1) begin
      bad++;
      $display("FAIL fill_8 got stall=%b num=%0d vld=%b iid=%0d want 1 8 1 1",
               biq_mask_stall_ctrl, biq_mask_num, x_lsiq_vld, x_lsiq_iid);
    end
    do_cycle(1'b1, 7'd9, 1'b0, 7'd0, 1'b0, 1'b0);
    total++;
    if (biq_mask_num !== 4'd8 || x_lsiq_iid !== 7'd1) begin
      bad++;
      $display("FAIL fill_9th_ignored got num=%0d iid=%0d want 8 1", biq_mask_num, x_lsiq_iid);
    end
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (x_lsiq_iid !== 7'(i) || x_lsiq_vld !== 1'b1) begin
        bad++;
        $display("FAIL drain_order got vld=%b iid=%0d want 1 %0d", x_lsiq_vld, x_lsiq_iid, i);
      end
      do_cycle(1'b0, 7'd0, 1'b1, 7'(i), 1'b1, 1'b0);
    end
    total++;
    if (biq_mask_num !== 4'd0 || x_lsiq_vld !== 1'b0 || x_lsiq_iid !== 7'd0
        || biq_mask_err !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty got num=%0d vld=%b iid=%0d err=%b want 0 0 0 0",
               biq_mask_num, x_lsiq_vld, x_lsiq_iid, biq_mask_err);
    end
  endtask

  task automatic test_wrap();
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 7'(10 + i), 1'b0, 7'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (x_lsiq_iid !== 7'(10 + i)) begin
        bad++;
        $display("FAIL wrap_pop got iid=%0d want %0d", x_lsiq_iid, 10 + i);
      end
      do_cycle(1'b0, 7'd0, 1'b1, 7'(10 + i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 7'(18 + i), 1'b0, 7'd0, 1'b0, 1'b0);
    total++;
    if (biq_mask_num !== 4'd8 || x_lsiq_iid !== 7'd15 || biq_mask_stall_ctrl !== 1'b1) begin
      bad++;
      $display("FAIL wrap_full got num=%0d iid=%0d stall=%b want 8 15 1",
               biq_mask_num, x_lsiq_iid, biq_mask_stall_ctrl);
    end
    for (int i = 15; i <= 22; i++) begin
      total++;
      if (x_lsiq_iid !== 7'(i) || x_lsiq_vld !== 1'b1) begin
        bad++;
        $display("FAIL wrap_order got vld=%b iid=%0d want 1 %0d", x_lsiq_vld, x_lsiq_iid, i);
      end
      do_cycle(1'b0, 7'd0, 1'b1, 7'(i), 1'b1, 1'b0);
    end
    total++;
    if (biq_mask_num !== 4'd0 || biq_mask_err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_empty got num=%0d err=%b want 0 0", biq_mask_num, biq_mask_err);
    end
  endtask

  task automatic test_back_to_back();
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    do_cycle(1'b1, 7'd30, 1'b0, 7'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 7'd31, 1'b1, 7'd30, 1'b1, 1'b0);
    total++;
    if (biq_mask_num !== 4'd1 || x_lsiq_iid !== 7'd31) begin
      bad++;
      $display("FAIL create_and_pop got num=%0d iid=%0d want 1 31", biq_mask_num, x_lsiq_iid);
    end
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 7'(32 + i), 1'b0, 7'd0, 1'b0, 1'b0);
    // Full: the create must be refused even though the head pops this cycle.
    do_cycle(1'b1, 7'd50, 1'b1, 7'd31, 1'b1, 1'b0);
    total++;
    if (biq_mask_num !== 4'd7 || x_lsiq_iid !== 7'd32 || biq_mask_stall_ctrl !== 1'b0) begin
      bad++;
      $display("FAIL full_create_pop got num=%0d iid=%0d stall=%b want 7 32 0",
               biq_mask_num, x_lsiq_iid, biq_mask_stall_ctrl);
    end
  endtask

  task automatic test_mispredict();
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    for (int i = 3; i <= 5; i++) do_cycle(1'b1, 7'(i), 1'b0, 7'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 7'd6, 1'b1, 7'd3, 1'b0, 1'b0);
    total++;
    if (biq_mask_num !== 4'd0 || x_lsiq_vld !== 1'b0 || x_lsiq_iid !== 7'd0
        || biq_mask_err !== 1'b0) begin
      bad++;
      $display("FAIL mispredict got num=%0d vld=%b iid=%0d err=%b want 0 0 0 0",
               biq_mask_num, x_lsiq_vld, x_lsiq_iid, biq_mask_err);
    end
    do_cycle(1'b1, 7'd7, 1'b0, 7'd0, 1'b0, 1'b0);
    total++;
    if (biq_mask_num !== 4'd1 || x_lsiq_iid !== 7'd7) begin
      bad++;
      $display("FAIL post_mispredict got num=%0d iid=%0d want 1 7", biq_mask_num, x_lsiq_iid);
    end
  endtask

  task automatic test_mismatch();
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    do_cycle(1'b1, 7'd3, 1'b0, 7'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 7'd4, 1'b0, 7'd0, 1'b0, 1'b0);
    do_cycle(1'b0, 7'd0, 1'b1, 7'd4, 1'b1, 1'b0);
    total++;
    if (biq_mask_err !== 1'b1 || biq_mask_num !== 4'd2 || x_lsiq_iid !== 7'd3) begin
      bad++;
      $display("FAIL mismatch got err=%b num=%0d iid=%0d want 1 2 3",
               biq_mask_err, biq_mask_num, x_lsiq_iid);
    end
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    do_cycle(1'b0, 7'd0, 1'b1, 7'd3, 1'b1, 1'b0);
    total++;
    if (biq_mask_err !== 1'b1 || biq_mask_num !== 4'd1 || x_lsiq_iid !== 7'd4) begin
      bad++;
      $display("FAIL err_sticky got err=%b num=%0d iid=%0d want 1 1 4",
               biq_mask_err, biq_mask_num, x_lsiq_iid);
    end
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    total++;
    if (biq_mask_err !== 1'b0 || biq_mask_num !== 4'd0) begin
      bad++;
      $display("FAIL err_flush got err=%b num=%0d want 0 0", biq_mask_err, biq_mask_num);
    end
    do_cycle(1'b0, 7'd0, 1'b1, 7'd9, 1'b1, 1'b0);
    total++;
    if (biq_mask_err !== 1'b1 || biq_mask_num !== 4'd0) begin
      bad++;
      $display("FAIL err_empty got err=%b num=%0d want 1 0", biq_mask_err, biq_mask_num);
    end
  endtask

  task automatic test_flush();
    do_cycle(1'b1, 7'd1, 1'b0, 7'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 7'd2, 1'b0, 7'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 7'd3, 1'b1, 7'd1, 1'b1, 1'b1);
    total++;
    if ({biq_mask_stall_ctrl, biq_mask_num, x_lsiq_vld, x_lsiq_iid, biq_mask_err} !== 14'd0) begin
      bad++;
      $display("FAIL flush_all got stall=%b num=%0d vld=%b iid=%0d err=%b want all 0",
               biq_mask_stall_ctrl, biq_mask_num, x_lsiq_vld, x_lsiq_iid, biq_mask_err);
    end
  endtask

  task automatic test_bypass();
    bit       exp_vld;
    bit [6:0] exp_iid;
`ifdef IDU_BJU_MASK_BYPASS_EN
    exp_vld = 1'b1; exp_iid = 7'd9;
`else
    exp_vld = 1'b0; exp_iid = 7'd0;
`endif
    do_cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    idu_idu_is_vld = 1'b1; idu_idu_is_pipe = 5'b00100; rtu_idu_is_iid = 7'd9;
    #1;
    total++;
    if (x_lsiq_vld !== exp_vld || x_lsiq_iid !== exp_iid) begin
      bad++;
      $display("FAIL bypass_same_cycle got vld=%b iid=%0d want %b %0d",
               x_lsiq_vld, x_lsiq_iid, exp_vld, exp_iid);
    end
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if (x_lsiq_vld !== 1'b1 || x_lsiq_iid !== 7'd9 || biq_mask_num !== 4'd1) begin
      bad++;
      $display("FAIL bypass_next_cycle got vld=%b iid=%0d num=%0d want 1 9 1",
               x_lsiq_vld, x_lsiq_iid, biq_mask_num);
    end
  endtask

  task automatic test_reset_mid();
    do_cycle(1'b1, 7'd40, 1'b0, 7'd0, 1'b0, 1'b0);
    idu_idu_is_vld = 1'b1; idu_idu_is_pipe = 5'b00100; rtu_idu_is_iid = 7'd41;
    bju_resolve_vld = 1'b1; bju_resolve_iid = 7'd77; bju_resolve_nojump = 1'b1;
    #2;
    rst_clk = 1'b1;
    #1;
    total++;
    if (biq_mask_num !== 4'd0 || x_lsiq_vld !== 1'b0 || x_lsiq_iid !== 7'd0) begin
      bad++;
      $display("FAIL reset_async got num=%0d vld=%b iid=%0d want 0 0 0",
               biq_mask_num, x_lsiq_vld, x_lsiq_iid);
    end
    @(posedge clk); #1;
    total++;
    if (biq_mask_num !== 4'd0 || biq_mask_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got num=%0d err=%b want 0 0", biq_mask_num, biq_mask_err);
    end
    idle_inputs();
    rst_clk = 1'b0;
    do_cycle(1'b1, 7'd5, 1'b0, 7'd0, 1'b0, 1'b0);
    total++;
    if (biq_mask_num !== 4'd1 || x_lsiq_iid !== 7'd5 || biq_mask_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_resume got num=%0d iid=%0d err=%b want 1 5 0",
               biq_mask_num, x_lsiq_iid, biq_mask_err);
    end
  endtask

  initial begin
    test_reset();
    test_create_qual();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_mispredict();
    test_mismatch();
    test_flush();
    test_bypass();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
